fpu_sched: RTL and testbench
============================

# fpu_sched

Issue scheduler for the execution stage's multi-cycle units: fadd, fmul, finv, fsqrt, floor, itof, ftoi, plus memory loads. It tracks every in-flight destination register and gives each accepted operation a single-cycle slot on the shared register write port. It also time-shares the single fmul instance between FMUL and the second phase of FDIV (finv then fmul). The decode/exec front end presents one operation per cycle and advances only on `issue_valid && issue_ready`. The datapath units are steered by this block's outputs.

## Interface
Parameters:
- `MAXLAT`, 8: longest supported latency; sets the reservation depth.
- `FDIV_INV_LAT`, 4: edges from FDIV issue to the fmul hand-off.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `issue_valid` in 1: the front end presents an operation.
- `issue_op` in 4: op class, `op_class_t`.
- `issue_rd` in 5: destination register number.
- `issue_rd_f` in 1: destination is in the float file.
- `issue_rs`, `issue_rt` in 5 each: source register numbers.
- `issue_rs_f`, `issue_rt_f` in 1 each: source is in the float file.
- `issue_rs_used`, `issue_rt_used` in 1 each: the source is actually read.
- `issue_ready` out 1: combinational; the operation is accepted at this edge.
- `fmul_sel_div` out 1: registered; fmul operands come from the FDIV phase-2 path (`fdiv_s` and `finv_d`) at the next edge.
- `wb_valid` out 1: registered; write-port strobe.
- `wb_rd` out 5: registered; write-port register number.
- `wb_f` out 1: registered; write-port register file select.
- `wb_op` out 4: registered; op class being written, used by the data mux.
- `idle` out 1: combinational; nothing in flight.

## Operation
- Op classes and latency L (edges from issue to writeback):
  - NOWB: L=0, no writeback (stores, branches, j, outb).
  - ALU: L=1.
  - FTOI: L=1.
  - LOAD: L=2.
  - FLOOR: L=2.
  - ITOF: L=2.
  - FADD (also FSUB): L=4.
  - FMUL: L=4.
  - SQRT: L=6.
  - FDIV: L=8.
- Pending bitmap `pend[63:0]`: index is `{f, reg}`.
  - Set at the accepting edge for any op with L>0, unless the destination is integer x0.
  - Cleared at the edge where that op's `wb_valid` rises.
  - Integer x0 is never pending and never written back. An op writing integer x0 consumes no write slot.
- `issue_ready = rstn && issue_valid && !raw && !waw && !wb_conf && !fmul_conf`.
  - `raw`: a used source is pending. There is no bypass credit: an op completing this cycle still blocks.
  - `waw`: the destination is pending.
  - `wb_conf`: the write slot at edge k+L is already reserved.
  - `fmul_conf`: the op is FMUL and an FDIV phase 2 claims fmul at edge k.
- Write-slot ring `wbr[MAXLAT:1]`.
  - Each entry holds `{valid, rd, f, op}`.
  - Shifts toward 1 every edge.
  - An accepted op with L>0 fills the entry that reaches the output exactly L edges later.
  - The output entry registers onto `wb_*`.
- fmul claim chain `fc[FDIV_INV_LAT:1]`.
  - FDIV issue sets the top bit; the chain shifts each edge.
  - `fmul_sel_div` = the bit that means "claimed at next edge".
  - Two FDIVs on consecutive edges occupy distinct bits; both are legal.
- FDIV and FMUL produce one fmul result each per issue slot. Both write back through the same ring.

## Timing
- Accept at edge k → `wb_valid` high for exactly one cycle, starting at edge k+L.
- Throughput is one issue per cycle when there are no hazards.
- Reset (`rstn`=0 at an edge):
  - `pend`, `wbr`, `fc` cleared.
  - `wb_valid`=0, `wb_rd`=0, `wb_f`=0, `wb_op`=NOWB, `fmul_sel_div`=0.
  - `issue_ready`=0 while `rstn`=0.
  - Reset mid-operation discards all in-flight ops; no late `wb_valid` appears.
- Simultaneous writeback and issue to the same register at edge k: the clear wins for the old op. The new issue is still blocked by `waw` because `waw` is evaluated on pre-edge `pend`.
- `idle` = no bit set in `pend`, `wbr` or `fc`.

## Structure
- `fpu_sched_pkg`:
  - `op_class_t` enum.
  - `lat_of()` function returning the L values.
  - `MAXLAT` and `FDIV_INV_LAT` defaults.
  - Ring entry struct.
- Sub-module `wb_slot_ring`: the parameterised write-slot shift register with reserve and conflict query. Instantiated once. The claim chain is inline.

## Test plan
- Accept FADD to f3 at edge 10 → `wb_valid` at edge 14 with `wb_rd`=3, `wb_f`=1. `pend[35]` clears at edge 14.
- FADD to f3 at edge 10, then at edge 11 FADD reading f3 → `issue_ready`=0 through edge 14. Accepted at edge 15; its writeback is at edge 19.
- SQRT at edge 0 (L=6), then FADD at edge 2 (L=4) → FADD is rejected for the slot at edge 6. It is accepted at edge 3 and writes back at edge 7.
- FDIV at edge 0 → `fmul_sel_div` high in the cycle before edge 4. FMUL offered at edge 4 is stalled one edge. FDIV writes back at edge 8.
- ALU write to integer x0 plus a NOWB store → neither sets `pend` and neither produces `wb_valid`. `idle` stays 1.
- Assert `rstn`=0 at edge 3 with FDIV and SQRT in flight → no `wb_valid` afterwards, and `idle`=1 at edge 4.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the multi-cycle issue scheduler.
package fpu_sched_pkg;

    localparam int DEF_MAXLAT       = 8;
    localparam int DEF_FDIV_INV_LAT = 4;
    localparam int LATW             = 4;

    typedef enum logic [3:0] {
        OP_NOWB  = 4'd0,
        OP_ALU   = 4'd1,
        OP_FTOI  = 4'd2,
        OP_LOAD  = 4'd3,
        OP_FLOOR = 4'd4,
        OP_ITOF  = 4'd5,
        OP_FADD  = 4'd6,
        OP_FMUL  = 4'd7,
        OP_SQRT  = 4'd8,
        OP_FDIV  = 4'd9
    } op_class_t;

    // One reservation on the shared register write port.
    typedef struct packed {
        logic      valid;
        logic [4:0] rd;
        logic      f;
        op_class_t op;
    } wb_entry_t;

    // Edges from issue to writeback; unknown encodings behave as NOWB.
    function automatic logic [LATW-1:0] lat_of(input op_class_t op);
        logic [LATW-1:0] lat;
        case (op)
            OP_NOWB:  lat = 4'd0;
            OP_ALU:   lat = 4'd1;
            OP_FTOI:  lat = 4'd1;
            OP_LOAD:  lat = 4'd2;
            OP_FLOOR: lat = 4'd2;
            OP_ITOF:  lat = 4'd2;
            OP_FADD:  lat = 4'd4;
            OP_FMUL:  lat = 4'd4;
            OP_SQRT:  lat = 4'd6;
            OP_FDIV:  lat = 4'd8;
            default:  lat = 4'd0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_sched_wb_slot_ring.sv
// Write-slot reservation ring: entry j reaches the write port j edges later.
module wb_slot_ring
    import fpu_sched_pkg::*;
#(
    parameter int DEPTH = DEF_MAXLAT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rsv_valid,
    input  logic [LATW-1:0] rsv_lat,
    input  wb_entry_t       rsv_entry,
    input  logic            q_valid,
    input  logic [LATW-1:0] q_lat,
    output logic            q_conf,
    output wb_entry_t       head,
    output logic            any_valid
);

    wb_entry_t ring_r     [1:DEPTH];
    wb_entry_t shift_s    [1:DEPTH];
    wb_entry_t ring_nxt_s [1:DEPTH];

    // Shift toward the output and drop a new reservation into its latency slot.
    always_comb begin
        for (int j = 1; j < DEPTH; j++) begin
            shift_s[j] = ring_r[j+1];
        end
        shift_s[DEPTH] = '0;
        for (int j = 1; j <= DEPTH; j++) begin
            ring_nxt_s[j] = (rsv_valid && (int'(rsv_lat) == j)) ? rsv_entry : shift_s[j];
        end
    end

    // A slot at latency L is taken if the entry one place further up is valid,
    // since it shifts into position L at the same edge.
    always_comb begin
        q_conf    = 1'b0;
        any_valid = 1'b0;
        for (int j = 2; j <= DEPTH; j++) begin
            q_conf = q_conf | (q_valid && ((int'(q_lat) + 1) == j) && ring_r[j].valid);
        end
        for (int j = 1; j <= DEPTH; j++) begin
            any_valid = any_valid | ring_r[j].valid;
        end
    end

    assign head = ring_r[1];

    // Ring storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int j = 1; j <= DEPTH; j++) begin
                ring_r[j] <= '0;
            end
        end else begin
            for (int j = 1; j <= DEPTH; j++) begin
                ring_r[j] <= ring_nxt_s[j];
            end
        end
    end

endmodule

// File: rtl/fpu_sched.sv
// Issue scheduler: hazard checks, write-port slot allocation and fmul sharing
// between FMUL and the second phase of FDIV.
module fpu_sched
    import fpu_sched_pkg::*;
#(
    parameter int MAXLAT       = DEF_MAXLAT,
    parameter int FDIV_INV_LAT = DEF_FDIV_INV_LAT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       issue_valid,
    input  logic [3:0] issue_op,
    input  logic [4:0] issue_rd,
    input  logic       issue_rd_f,
    input  logic [4:0] issue_rs,
    input  logic [4:0] issue_rt,
    input  logic       issue_rs_f,
    input  logic       issue_rt_f,
    input  logic       issue_rs_used,
    input  logic       issue_rt_used,
    output logic       issue_ready,
    output logic       fmul_sel_div,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_f,
    output logic [3:0] wb_op,
    output logic       idle
);

    logic [63:0]           pend_r;
    logic [FDIV_INV_LAT:1] fc_r;
    logic                  wb_valid_r;
    logic [4:0]            wb_rd_r;
    logic                  wb_f_r;
    op_class_t             wb_op_r;

    op_class_t       op_s;
    logic [LATW-1:0] lat_s;
    logic            wr_x0_s;
    logic            needs_slot_s;
    logic            raw_s;
    logic            waw_s;
    logic            wb_conf_s;
    logic            fmul_conf_s;
    logic            accept_s;
    logic            reserve_s;
    logic [63:0]     set_mask_s;
    logic [63:0]     clr_mask_s;
    wb_entry_t       rsv_entry_s;
    wb_entry_t       head_s;
    logic            ring_any_s;

    // Decode the offered op and evaluate all hazards against pre-edge state.
    always_comb begin
        op_s         = op_class_t'(issue_op);
        lat_s        = lat_of(op_s);
        wr_x0_s      = !issue_rd_f && (issue_rd == 5'd0);
        needs_slot_s = (lat_s != 4'd0) && !wr_x0_s;
        raw_s        = (issue_rs_used && pend_r[{issue_rs_f, issue_rs}]) ||
                       (issue_rt_used && pend_r[{issue_rt_f, issue_rt}]);
        waw_s        = needs_slot_s && pend_r[{issue_rd_f, issue_rd}];
        fmul_conf_s  = (op_s == OP_FMUL) && fc_r[1];
        accept_s     = rstn && issue_valid && !raw_s && !waw_s && !wb_conf_s && !fmul_conf_s;
        reserve_s    = accept_s && needs_slot_s;
        rsv_entry_s  = '{valid: 1'b1, rd: issue_rd, f: issue_rd_f, op: op_s};
    end

    // Pending-bit update masks: retire the op leaving the ring, add the new one.
    always_comb begin
        set_mask_s = 64'd0;
        clr_mask_s = 64'd0;
        if (reserve_s) begin
            set_mask_s[{issue_rd_f, issue_rd}] = 1'b1;
        end else begin
            set_mask_s = 64'd0;
        end
        if (head_s.valid) begin
            clr_mask_s[{head_s.f, head_s.rd}] = 1'b1;
        end else begin
            clr_mask_s = 64'd0;
        end
    end

    wb_slot_ring #(.DEPTH(MAXLAT)) u_ring (
        .clk       (clk),
        .rstn      (rstn),
        .rsv_valid (reserve_s),
        .rsv_lat   (lat_s),
        .rsv_entry (rsv_entry_s),
        .q_valid   (needs_slot_s),
        .q_lat     (lat_s),
        .q_conf    (wb_conf_s),
        .head      (head_s),
        .any_valid (ring_any_s)
    );

    // Pending destination bitmap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_r <= 64'd0;
        end else begin
            pend_r <= (pend_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // fmul claim chain: bit 1 means FDIV phase 2 owns fmul at the next edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fc_r <= '0;
        end else begin
            for (int j = 1; j < FDIV_INV_LAT; j++) begin
                fc_r[j] <= fc_r[j+1];
            end
            fc_r[FDIV_INV_LAT] <= accept_s && (op_s == OP_FDIV);
        end
    end

    // Register the ring head onto the write port.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_f_r     <= 1'b0;
            wb_op_r    <= OP_NOWB;
        end else begin
            wb_valid_r <= head_s.valid;
            wb_rd_r    <= head_s.rd;
            wb_f_r     <= head_s.f;
            wb_op_r    <= head_s.op;
        end
    end

    assign issue_ready  = accept_s;
    assign fmul_sel_div = fc_r[1];
    assign wb_valid     = wb_valid_r;
    assign wb_rd        = wb_rd_r;
    assign wb_f         = wb_f_r;
    assign wb_op        = wb_op_r;
    assign idle         = !(|pend_r) && !ring_any_s && !(|fc_r);

endmodule

// File: tb/tb_fpu_sched.sv
// Directed bench for fpu_sched: edges are counted relative to each scenario.
module tb_fpu_sched;
    import fpu_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       issue_valid;
    logic [3:0] issue_op;
    logic [4:0] issue_rd;
    logic       issue_rd_f;
    logic [4:0] issue_rs;
    logic [4:0] issue_rt;
    logic       issue_rs_f;
    logic       issue_rt_f;
    logic       issue_rs_used;
    logic       issue_rt_used;
    logic       issue_ready;
    logic       fmul_sel_div;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_f;
    logic [3:0] wb_op;
    logic       idle;

    int tests_run = 0;
    int tests_failed = 0;

    fpu_sched dut (
        .clk(clk), .rstn(rstn),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_rd_f(issue_rd_f),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rs_f(issue_rs_f), .issue_rt_f(issue_rt_f),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
        .issue_ready(issue_ready), .fmul_sel_div(fmul_sel_div),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_f(wb_f), .wb_op(wb_op),
        .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                         input logic rdf, input logic [4:0] rs, input logic rsf,
                         input logic rsu);
        issue_valid   = v;
        issue_op      = op;
        issue_rd      = rd;
        issue_rd_f    = rdf;
        issue_rs      = rs;
        issue_rs_f    = rsf;
        issue_rs_used = rsu;
        issue_rt      = 5'd0;
        issue_rt_f    = 1'b0;
        issue_rt_used = 1'b0;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        while (!idle && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_idle: got %0b expected 1", idle);
        end
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(1'b1, OP_ALU, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        tests_run++;
        if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0b expected 0", issue_ready); end
        tests_run++;
        if ({wb_valid, wb_rd, wb_f, wb_op, fmul_sel_div} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%0b rd=%0d f=%0b op=%0d sel=%0b expected all 0", wb_valid, wb_rd, wb_f, wb_op, fmul_sel_div);
        end
        tests_run++;
        if (idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %0b expected 1", idle); end
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rstn = 1'b1;
        step();
    endtask

    task automatic test_raw_fadd();
        drive(1'b1, OP_FADD, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_first_ready: got %0b expected 1", issue_ready); end
        step();
        drive(1'b1, OP_FADD, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1);
        for (int e = 1; e <= 4; e++) begin
            tests_run++;
            if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL raw_stall e%0d: got %0b expected 0", e, issue_ready); end
            step();
            tests_run++;
            if (wb_valid !== (e == 4)) begin tests_failed++; $display("FAIL raw_wb_valid e%0d: got %0b expected %0b", e, wb_valid, e == 4); end
        end
        tests_run++;
        if ({wb_rd, wb_f, wb_op} !== {5'd3, 1'b1, 4'(OP_FADD)}) begin
            tests_failed++;
            $display("FAIL raw_wb_fields: got rd=%0d f=%0b op=%0d expected rd=3 f=1 op=6", wb_rd, wb_f, wb_op);
        end
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL raw_release: got %0b expected 1", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int e = 6; e <= 9; e++) begin
            step();
            tests_run++;
            if (wb_valid !== (e == 9)) begin tests_failed++; $display("FAIL raw_second_wb e%0d: got %0b expected %0b", e, wb_valid, e == 9); end
        end
        tests_run++;
        if ({wb_rd, wb_f, idle} !== {5'd4, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL raw_second_fields: got rd=%0d f=%0b idle=%0b expected rd=4 f=1 idle=1", wb_rd, wb_f, idle);
        end
        drain();
    endtask

    task automatic test_slot_conflict();
        drive(1'b1, OP_SQRT, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL slot_sqrt_ready: got %0b expected 1", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, OP_FADD, 5'd6, 1'b1, 5'd1, 1'b1, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL slot_conflict: got %0b expected 0", issue_ready); end
        step();
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL slot_free: got %0b expected 1", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int e = 4; e <= 8; e++) begin
            step();
            tests_run++;
            if (wb_valid !== (e == 6 || e == 7)) begin tests_failed++; $display("FAIL slot_wb e%0d: got %0b expected %0b", e, wb_valid, e == 6 || e == 7); end
            if (e == 6) begin
                tests_run++;
                if ({wb_rd, wb_op} !== {5'd5, 4'(OP_SQRT)}) begin tests_failed++; $display("FAIL slot_sqrt_wb: got rd=%0d op=%0d expected rd=5 op=8", wb_rd, wb_op); end
            end
            if (e == 7) begin
                tests_run++;
                if ({wb_rd, wb_op} !== {5'd6, 4'(OP_FADD)}) begin tests_failed++; $display("FAIL slot_fadd_wb: got rd=%0d op=%0d expected rd=6 op=6", wb_rd, wb_op); end
            end
        end
        drain();
    endtask

    task automatic test_fdiv_fmul();
        drive(1'b1, OP_FDIV, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL fdiv_ready: got %0b expected 1", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            if (e > 1) step();
            tests_run++;
            if (fmul_sel_div !== 1'b0) begin tests_failed++; $display("FAIL fdiv_sel_early e%0d: got %0b expected 0", e - 1, fmul_sel_div); end
        end
        step();
        tests_run++;
        if (fmul_sel_div !== 1'b1) begin tests_failed++; $display("FAIL fdiv_sel_e3: got %0b expected 1", fmul_sel_div); end
        drive(1'b1, OP_FMUL, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL fmul_stall: got %0b expected 0", issue_ready); end
        step();
        tests_run++;
        if (fmul_sel_div !== 1'b0) begin tests_failed++; $display("FAIL fdiv_sel_e4: got %0b expected 0", fmul_sel_div); end
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL fmul_accept: got %0b expected 1", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int e = 6; e <= 10; e++) begin
            step();
            tests_run++;
            if (wb_valid !== (e == 8 || e == 9)) begin tests_failed++; $display("FAIL fdiv_wb e%0d: got %0b expected %0b", e, wb_valid, e == 8 || e == 9); end
            if (e == 8) begin
                tests_run++;
                if ({wb_rd, wb_op} !== {5'd7, 4'(OP_FDIV)}) begin tests_failed++; $display("FAIL fdiv_wb_fields: got rd=%0d op=%0d expected rd=7 op=9", wb_rd, wb_op); end
            end
            if (e == 9) begin
                tests_run++;
                if ({wb_rd, wb_op} !== {5'd8, 4'(OP_FMUL)}) begin tests_failed++; $display("FAIL fmul_wb_fields: got rd=%0d op=%0d expected rd=8 op=7", wb_rd, wb_op); end
            end
        end
        drain();
    endtask

    task automatic test_fdiv_pair();
        drive(1'b1, OP_FDIV, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, OP_FDIV, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL fdiv_pair_ready: got %0b expected 1", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int e = 2; e <= 5; e++) begin
            step();
            tests_run++;
            if (fmul_sel_div !== (e == 3 || e == 4)) begin tests_failed++; $display("FAIL fdiv_pair_sel e%0d: got %0b expected %0b", e, fmul_sel_div, e == 3 || e == 4); end
        end
        drain();
    endtask

    task automatic test_x0_nowb();
        drive(1'b1, OP_ALU, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1);
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL x0_ready: got %0b expected 1", issue_ready); end
        step();
        drive(1'b1, OP_NOWB, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1);
        tests_run++;
        if (issue_ready !== 1'b1 || idle !== 1'b1) begin tests_failed++; $display("FAIL nowb_ready_idle: got ready=%0b idle=%0b expected 1 1", issue_ready, idle); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int e = 2; e <= 3; e++) begin
            tests_run++;
            if (wb_valid !== 1'b0 || idle !== 1'b1) begin tests_failed++; $display("FAIL x0_no_wb e%0d: got wb=%0b idle=%0b expected 0 1", e, wb_valid, idle); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, OP_ALU, 5'(i), 1'b0, 5'd0, 1'b0, 1'b0);
            tests_run++;
            if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready i%0d: got %0b expected 1", i, issue_ready); end
            step();
            if (i > 1) begin
                tests_run++;
                if ({wb_valid, wb_rd} !== {1'b1, 5'(i - 1)}) begin tests_failed++; $display("FAIL b2b_wb i%0d: got v=%0b rd=%0d expected v=1 rd=%0d", i, wb_valid, wb_rd, i - 1); end
            end
        end
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        tests_run++;
        if ({wb_valid, wb_rd, wb_op} !== {1'b1, 5'd3, 4'(OP_ALU)}) begin tests_failed++; $display("FAIL b2b_last: got v=%0b rd=%0d op=%0d expected v=1 rd=3 op=1", wb_valid, wb_rd, wb_op); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_FDIV, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, OP_SQRT, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_sqrt_ready: got %0b expected 1", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tests_run++;
        if (idle !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got idle=%0b expected 0", idle); end
        step();
        rstn = 1'b0;
        drive(1'b1, OP_FADD, 5'd14, 1'b1, 5'd0, 1'b0, 1'b0);
        tests_run++;
        if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_ready_in_reset: got %0b expected 0", issue_ready); end
        step();
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rstn = 1'b1;
        step();
        tests_run++;
        if (idle !== 1'b1) begin tests_failed++; $display("FAIL rmid_idle: got %0b expected 1", idle); end
        for (int e = 5; e <= 14; e++) begin
            tests_run++;
            if (wb_valid !== 1'b0 || fmul_sel_div !== 1'b0) begin tests_failed++; $display("FAIL rmid_late e%0d: got wb=%0b sel=%0b expected 0 0", e, wb_valid, fmul_sel_div); end
            step();
        end
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, OP_NOWB, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_raw_fadd();
        test_slot_conflict();
        test_fdiv_fmul();
        test_fdiv_pair();
        test_x0_nowb();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
